morse_frame_encoder: RTL and testbench

- Upstream feeder for `tickspeed_blinker`.
- Accepts ASCII characters over a valid/ready handshake and encodes each one into a Morse on/off bit pattern.
- Presents exactly one character per blinker frame on `blink_pattern`.
- Watches the blinker's `blink_index` so that a new frame is only swapped in at a frame boundary, never mid-frame.

---
 rtl/morse_pkg.sv | 40 ++++
 rtl/morse_frame_encoder_if.sv | 29 ++
 rtl/morse_lut.sv | 68 ++++++
 rtl/morse_frame_encoder.sv | 179 +++++++++++++++++
 tb/tb_morse_frame_encoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : morse_pkg
// Brief   : Shared types and constants for the Morse frame encoder.
// Revision: 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DOT_BITS          = 1;
    localparam int DASH_BITS         = 3;
    localparam int SYM_GAP           = 1;
    localparam int LETTER_GAP        = 3;
    localparam int MIN_MESSAGE_WIDTH = 22;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] code;
        logic       supported;
    } morse_code_t;

    // Table entries are written right-aligned; the stored code is left-aligned
    // so the first symbol always sits in code[4].
    function automatic morse_code_t morse_entry(input logic [2:0] len,
                                                input logic [4:0] code_r);
        morse_code_t e;
        e.len       = len;
        e.code      = code_r << (3'd5 - len);
        e.supported = 1'b1;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_frame_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : morse_frame_encoder_if
// Brief   : Character handshake and blinker frame signals of the encoder.
// Revision: 1.0 - initial release
// ============================================================================
interface morse_frame_encoder_if #(
    parameter int MESSAGE_WIDTH = 32,
    parameter int INDEX_WIDTH   = 5
);
    logic [7:0]               char_in;
    logic                     char_valid;
    logic                     char_ready;
    logic [INDEX_WIDTH-1:0]   blink_index;
    logic [MESSAGE_WIDTH-1:0] blink_pattern;
    logic                     pattern_valid;
    logic                     char_err;

    modport master (
        output char_in, char_valid, blink_index,
        input  char_ready, blink_pattern, pattern_valid, char_err
    );

    modport slave (
        input  char_in, char_valid, blink_index,
        output char_ready, blink_pattern, pattern_valid, char_err
    );
endinterface
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// ============================================================================
// Module  : morse_lut
// Brief   : Combinational ASCII to Morse code ROM (lower case folds to upper).
// Revision: 1.0 - initial release
// ============================================================================
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0]  char_in,
    output morse_code_t code_out
);

    logic [7:0] folded;

    always_comb begin
        folded = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            folded = char_in - 8'h20;
        end
    end

    always_comb begin
        code_out = '0;
        case (folded)
            8'h20: code_out = morse_entry(3'd0, 5'b00000);
            "A":   code_out = morse_entry(3'd2, 5'b00001);
            "B":   code_out = morse_entry(3'd4, 5'b01000);
            "C":   code_out = morse_entry(3'd4, 5'b01010);
            "D":   code_out = morse_entry(3'd3, 5'b00100);
            "E":   code_out = morse_entry(3'd1, 5'b00000);
            "F":   code_out = morse_entry(3'd4, 5'b00010);
            "G":   code_out = morse_entry(3'd3, 5'b00110);
            "H":   code_out = morse_entry(3'd4, 5'b00000);
            "I":   code_out = morse_entry(3'd2, 5'b00000);
            "J":   code_out = morse_entry(3'd4, 5'b00111);
            "K":   code_out = morse_entry(3'd3, 5'b00101);
            "L":   code_out = morse_entry(3'd4, 5'b00100);
            "M":   code_out = morse_entry(3'd2, 5'b00011);
            "N":   code_out = morse_entry(3'd2, 5'b00010);
            "O":   code_out = morse_entry(3'd3, 5'b00111);
            "P":   code_out = morse_entry(3'd4, 5'b00110);
            "Q":   code_out = morse_entry(3'd4, 5'b01101);
            "R":   code_out = morse_entry(3'd3, 5'b00010);
            "S":   code_out = morse_entry(3'd3, 5'b00000);
            "T":   code_out = morse_entry(3'd1, 5'b00001);
            "U":   code_out = morse_entry(3'd3, 5'b00001);
            "V":   code_out = morse_entry(3'd4, 5'b00001);
            "W":   code_out = morse_entry(3'd3, 5'b00011);
            "X":   code_out = morse_entry(3'd4, 5'b01001);
            "Y":   code_out = morse_entry(3'd4, 5'b01011);
            "Z":   code_out = morse_entry(3'd4, 5'b01100);
            "0":   code_out = morse_entry(3'd5, 5'b11111);
            "1":   code_out = morse_entry(3'd5, 5'b01111);
            "2":   code_out = morse_entry(3'd5, 5'b00111);
            "3":   code_out = morse_entry(3'd5, 5'b00011);
            "4":   code_out = morse_entry(3'd5, 5'b00001);
            "5":   code_out = morse_entry(3'd5, 5'b00000);
            "6":   code_out = morse_entry(3'd5, 5'b10000);
            "7":   code_out = morse_entry(3'd5, 5'b11000);
            "8":   code_out = morse_entry(3'd5, 5'b11100);
            "9":   code_out = morse_entry(3'd5, 5'b11110);
            default: code_out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module  : morse_frame_encoder
// Brief   : Encodes accepted ASCII characters into Morse frames and swaps one
//           frame per blinker frame boundary.
// Revision: 1.0 - initial release
// ============================================================================
module morse_frame_encoder
    import morse_pkg::*;
#(
    parameter int MESSAGE_WIDTH = 32,
    parameter int INDEX_WIDTH   = 5
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    morse_frame_encoder_if.slave  bus
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(MESSAGE_WIDTH - 1);

    if (MESSAGE_WIDTH < MIN_MESSAGE_WIDTH || INDEX_WIDTH != $clog2(MESSAGE_WIDTH)) begin : g_param_check
        $error("morse_frame_encoder: illegal MESSAGE_WIDTH/INDEX_WIDTH combination");
    end

    state_t                   state_q,         state_d;
    logic [7:0]               char_q,          char_d;
    logic [2:0]               len_q,           len_d;
    logic [4:0]               code_q,          code_d;
    logic [2:0]               sym_q,           sym_d;
    logic [1:0]               cnt_q,           cnt_d;
    logic                     gap_q,           gap_d;
    logic [INDEX_WIDTH-1:0]   ptr_q,           ptr_d;
    logic [MESSAGE_WIDTH-1:0] work_q,          work_d;
    logic [MESSAGE_WIDTH-1:0] pattern_q,       pattern_d;
    logic                     pattern_valid_q, pattern_valid_d;
    logic                     char_err_q,      char_err_d;
    logic [INDEX_WIDTH-1:0]   idx_q,           idx_d;

    morse_code_t lut_code;
    logic        boundary;
    logic        is_dash;
    logic        is_last;
    logic [1:0]  elem_last_cnt;

    morse_lut u_lut (
        .char_in  (char_q),
        .code_out (lut_code)
    );

    assign boundary = (idx_q == '0) && (bus.blink_index == LAST_INDEX);
    assign is_dash  = code_q[3'd4 - sym_q];
    assign is_last  = (sym_q == len_q - 3'd1);

    // Final count of the element currently being written: mark or gap.
    always_comb begin
        elem_last_cnt = 2'(DOT_BITS - 1);
        if (gap_q) begin
            elem_last_cnt = is_last ? 2'(LETTER_GAP - 1) : 2'(SYM_GAP - 1);
        end else if (is_dash) begin
            elem_last_cnt = 2'(DASH_BITS - 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q         <= IDLE;
            char_q          <= '0;
            len_q           <= '0;
            code_q          <= '0;
            sym_q           <= '0;
            cnt_q           <= '0;
            gap_q           <= 1'b0;
            ptr_q           <= '0;
            work_q          <= '0;
            pattern_q       <= '0;
            pattern_valid_q <= 1'b0;
            char_err_q      <= 1'b0;
            idx_q           <= '0;
        end else begin
            state_q         <= state_d;
            char_q          <= char_d;
            len_q           <= len_d;
            code_q          <= code_d;
            sym_q           <= sym_d;
            cnt_q           <= cnt_d;
            gap_q           <= gap_d;
            ptr_q           <= ptr_d;
            work_q          <= work_d;
            pattern_q       <= pattern_d;
            pattern_valid_q <= pattern_valid_d;
            char_err_q      <= char_err_d;
            idx_q           <= idx_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        char_d          = char_q;
        len_d           = len_q;
        code_d          = code_q;
        sym_d           = sym_q;
        cnt_d           = cnt_q;
        gap_d           = gap_q;
        ptr_d           = ptr_q;
        work_d          = work_q;
        pattern_d       = pattern_q;
        pattern_valid_d = pattern_valid_q;
        char_err_d      = 1'b0;
        idx_d           = bus.blink_index;

        case (state_q)
            IDLE: begin
                if (bus.char_valid) begin
                    char_d  = bus.char_in;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                work_d = '0;
                ptr_d  = '0;
                sym_d  = '0;
                cnt_d  = '0;
                gap_d  = 1'b0;
                len_d  = lut_code.len;
                code_d = lut_code.code;
                if (!lut_code.supported) begin
                    char_err_d = 1'b1;
                    state_d    = IDLE;
                end else if (lut_code.len == 3'd0) begin
                    state_d = HOLD;
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                ptr_d = ptr_q + 1'b1;
                if (!gap_q) begin
                    work_d[LAST_INDEX - ptr_q] = 1'b1;
                end
                if (cnt_q == elem_last_cnt) begin
                    cnt_d = '0;
                    if (!gap_q) begin
                        gap_d = 1'b1;
                    end else if (is_last) begin
                        state_d = HOLD;
                    end else begin
                        gap_d = 1'b0;
                        sym_d = sym_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase

        // A boundary without a finished frame shows dark rather than repeating.
        if (boundary) begin
            if (state_q == HOLD) begin
                pattern_d       = work_q;
                pattern_valid_d = 1'b1;
                state_d         = IDLE;
            end else begin
                pattern_d       = '0;
                pattern_valid_d = 1'b0;
            end
        end
    end

    assign bus.char_ready    = (state_q == IDLE);
    assign bus.blink_pattern = pattern_q;
    assign bus.pattern_valid = pattern_valid_q;
    assign bus.char_err      = char_err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_morse_frame_encoder
// Brief   : Self-checking bench for morse_frame_encoder with a blinker model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_morse_frame_encoder;

    localparam int MW = 32;
    localparam int IW = 5;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    morse_frame_encoder_if #(.MESSAGE_WIDTH(MW), .INDEX_WIDTH(IW)) bus ();

    morse_frame_encoder #(.MESSAGE_WIDTH(MW), .INDEX_WIDTH(IW)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    string morse_tab [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };
    logic [7:0] bad_chars [0:4] = '{8'h23, 8'h21, 8'h7E, 8'h00, 8'h40};

    int          n_checks, n_fail;
    int          cyc, tick_rate, div_cnt;
    int          n_commit, n_bound, pend_ready;
    logic [IW-1:0] prev_idx;
    bit          pend, unsup_busy, exp_pv, exp_err, last_acc;
    logic [MW-1:0] pend_pat, exp_pat;

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference encoding: dot=1, dash=111, 0 between symbols, 000 after the last.
    function automatic void encode(input logic [7:0] c, output bit ok,
                                   output logic [MW-1:0] pat, output int len);
        string s;
        int    pos, n, u;
        u  = (c >= 8'h61 && c <= 8'h7A) ? int'(c) - 32 : int'(c);
        ok = 1'b1;
        s  = "";
        if (u >= 65 && u <= 90)      s = morse_tab[u - 65];
        else if (u >= 48 && u <= 57) s = morse_tab[26 + u - 48];
        else if (u != 32)            ok = 1'b0;
        pat = '0;
        pos = 0;
        for (int k = 0; k < s.len(); k++) begin
            n = (s[k] == "-") ? 3 : 1;
            for (int j = 0; j < n; j++) begin
                pat[MW-1-pos] = 1'b1;
                pos++;
            end
            pos += (k == s.len() - 1) ? 3 : 1;
        end
        len = pos;
    endfunction

    task automatic tick();
        bit            acc, rst_edge, boundary, ok;
        logic [IW-1:0] idx_now;
        logic [7:0]    c_now;
        logic [MW-1:0] pat;
        int            len;
        acc      = bus.char_valid && bus.char_ready && RESETN;
        rst_edge = !RESETN;
        idx_now  = bus.blink_index;
        c_now    = bus.char_in;
        @(posedge CLK);
        #1;
        cyc++;
        last_acc = acc;
        boundary = (prev_idx == '0) && (idx_now == IW'(MW - 1));
        prev_idx = rst_edge ? '0 : idx_now;
        if (rst_edge) begin
            pend = 0; unsup_busy = 0; exp_pat = '0; exp_pv = 0; exp_err = 0;
        end else begin
            exp_err    = unsup_busy;
            unsup_busy = 0;
            if (boundary) begin
                n_bound++;
                if (pend && cyc >= pend_ready) begin
                    exp_pat = pend_pat; exp_pv = 1; pend = 0; n_commit++;
                end else begin
                    exp_pat = '0; exp_pv = 0;
                end
            end
            if (acc) begin
                encode(c_now, ok, pat, len);
                if (ok) begin
                    pend = 1; pend_pat = pat; pend_ready = cyc + 2 + len;
                end else begin
                    unsup_busy = 1;
                end
            end
        end
        check("pattern", bus.blink_pattern, exp_pat);
        check("pattern_valid", bus.pattern_valid, exp_pv);
        check("char_ready", bus.char_ready, !pend && !unsup_busy);
        check("char_err", bus.char_err, exp_err);
        div_cnt++;
        if (div_cnt >= tick_rate) begin
            div_cnt = 0;
            bus.blink_index = (bus.blink_index == '0) ? IW'(MW - 1) : bus.blink_index - 1'b1;
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int k;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        k = 0;
        last_acc = 0;
        while (!last_acc && k < 400) begin
            tick();
            k++;
        end
        bus.char_valid = 1'b0;
        check("send_accepted", last_acc, 1);
    endtask

    task automatic wait_commit();
        int start, k;
        start = n_commit;
        k = 0;
        while (n_commit == start && k < 400) begin
            tick();
            k++;
        end
        check("commit_seen", n_commit != start, 1);
    endtask

    task automatic wait_boundary();
        int start, k;
        start = n_bound;
        k = 0;
        while (n_bound == start && k < 400) begin
            tick();
            k++;
        end
        check("boundary_seen", n_bound != start, 1);
    endtask

    task automatic wait_index(input int v);
        int k;
        k = 0;
        while (!(bus.blink_index == IW'(v) && div_cnt == 0) && k < 400) begin
            tick();
            k++;
        end
        check("index_reached", bus.blink_index, IW'(v));
    endtask

    initial begin
        int         b0, r;
        logic [7:0] c;
        n_checks = 0; n_fail = 0; cyc = 0; n_commit = 0; n_bound = 0;
        pend = 0; unsup_busy = 0; exp_pv = 0; exp_err = 0; exp_pat = '0;
        pend_pat = '0; pend_ready = 0; prev_idx = '0; last_acc = 0;
        tick_rate = 2; div_cnt = 0;
        RESETN = 1'b0;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        bus.blink_index = IW'(MW - 1);
        repeat (3) tick();
        check("reset_ready", bus.char_ready, 1);
        RESETN = 1'b1;
        tick();

        send_char("E");
        wait_commit();
        check("E_frame", bus.blink_pattern, 32'h8000_0000);
        check("E_valid", bus.pattern_valid, 1);
        wait_boundary();
        check("E_cleared", bus.pattern_valid, 0);

        send_char("a");
        bus.char_in = "T";
        bus.char_valid = 1'b1;
        wait_commit();
        check("a_frame", bus.blink_pattern, 32'hB800_0000);
        b0 = n_bound;
        send_char("T");
        wait_commit();
        check("T_frame", bus.blink_pattern, 32'hE000_0000);
        check("aT_consecutive", n_bound - b0, 1);

        // Timed so that a 22-cycle EMIT lands in HOLD exactly at the boundary.
        wait_index(12);
        tick();
        tick();
        send_char("0");
        wait_boundary();
        check("zero_frame", bus.blink_pattern, 32'hEEEE_E000);
        check("zero_valid", bus.pattern_valid, 1);

        send_char("#");
        tick();
        check("hash_err_pulse", bus.char_err, 1);
        check("hash_ready", bus.char_ready, 1);
        tick();
        check("hash_err_end", bus.char_err, 0);
        send_char(" ");
        wait_commit();
        check("space_frame", bus.blink_pattern, 32'h0);
        check("space_valid", bus.pattern_valid, 1);

        wait_index(1);
        send_char("S");
        wait_boundary();
        check("S_dark_boundary", bus.pattern_valid, 0);
        wait_commit();
        check("S_frame", bus.blink_pattern, 32'hA800_0000);

        send_char("Q");
        repeat (4) tick();
        RESETN = 1'b0;
        repeat (3) tick();
        RESETN = 1'b1;
        tick();
        check("Q_rst_ready", bus.char_ready, 1);
        check("Q_rst_pattern", bus.blink_pattern, 32'h0);
        check("Q_rst_valid", bus.pattern_valid, 0);
        wait_boundary();
        check("Q_no_commit", bus.pattern_valid, 0);

        tick_rate = int'($urandom_range(2, 4));
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                c = 8'(8'h41 + $urandom_range(0, 25));
                if ($urandom_range(0, 1) == 1) c = c + 8'h20;
            end else if (r < 8) begin
                c = 8'(8'h30 + $urandom_range(0, 9));
            end else if (r == 8) begin
                c = 8'h20;
            end else begin
                c = bad_chars[$urandom_range(0, 4)];
            end
            send_char(c);
            repeat ($urandom_range(0, 40)) tick();
        end
        wait_boundary();
        wait_boundary();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
